spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

Read-only SPI NOR flash controller that serves byte fetches from the processor's instruction-memory region. It turns a parallel byte-read request (chip select, read strobe, 24-bit address) into a serial READ (0x03) transaction on a 4-wire SPI bus in mode 0, SCK = clk/2. It returns the fetched byte with a level `ready` handshake. It sits between the address decoder's instruction-memory select and an external serial flash.

## Interface
- Parameters: none. Address width is fixed at 24 bits and data width at 8 bits.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `chipSel` input, 1 bit: region select from the address decoder.
- `readMem` input, 1 bit: read strobe. A request is `chipSel && readMem`.
- `addressBus` input, 24 bits: flash byte address.
- `dataIn` input, 8 bits: write data. Ignored; writes are unsupported.
- `dataOut` output, 8 bits: last fetched byte. Held until the next fetch completes.
- `ready` output, 1 bit: `dataOut` is valid for the current request.
- `SCK` output, 1 bit: SPI clock. Idles low.
- `CSbar` output, 1 bit: flash select, active-low.
- `DI` output, 1 bit: serial data into the flash, MSB first.
- `DO` input, 1 bit: serial data from the flash.

## Operation
- States:
  - IDLE: CSbar=1, SCK=0, ready=0.
  - XFER: shifting bits.
  - DONE: presenting the result.
- IDLE to XFER: on a request.
  - Latch `addressBus`.
  - Load the 32-bit frame {8'h03, addr[23:0]}, then 8 read bits.
  - Drive CSbar=0 and DI = frame MSB.
- XFER: each bit spans 2 clk cycles.
  - Rising phase: SCK=1. Sample `DO` into the data shifter during data bits only.
  - Falling phase: SCK=0. Shift DI to the next frame bit. DI is 0 during data bits.
  - The 40 bits are 8 command, 24 address, 8 data.
- XFER to DONE: after the last falling phase.
  - Drive CSbar=1.
  - Load the data shifter into `dataOut`.
- DONE: `ready` = `chipSel && readMem && addressBus == latched address`.
  - Stay in DONE while that holds.
  - Otherwise go to IDLE. This guarantees at least 1 cycle of CSbar high between transactions.
- Request dropped or address changed during XFER:
  - The transaction completes; no abort.
  - `dataOut` still updates.
  - `ready` is not asserted. The controller then re-arms from IDLE.
- A sequential read is a new full transaction; no address auto-increment.
- Reset values: CSbar=1, SCK=0, DI=0, ready=0, dataOut=8'h00, state IDLE.
- Reset mid-transfer aborts immediately. The flash sees CSbar rise.

## Timing
- Edge 0: request seen in IDLE. After the edge, CSbar=0, SCK=0, DI=bit39.
- Edges 1, 3, …, 79: SCK rises. `DO` is sampled on edges 65, 67, …, 79 (data bit7 first).
- Edges 2, 4, …, 80: SCK falls; the next DI bit is presented.
- Edge 81: CSbar=1, `dataOut` updated, `ready`=1. Request-to-ready latency is 81 cycles.
- `ready` is combinational on DONE and the request/address compare. It drops the same cycle the request changes.
- The back-to-back minimum period is 83 cycles: DONE, then 1 IDLE cycle, then a new edge 0.

## Configuration
- `SPI_FLASH_FAST_READ_EN`: when defined, the command is 8'h0B and 8 dummy bits are inserted after the address.
  - Dummy bits drive DI=0 and are not sampled.
  - The frame is 48 bits, data is sampled on edges 81…95, and ready comes at edge 97.
- When undefined: command 8'h03, 40-bit frame, timing as above.

## Structure
- Package `spi_flash_pkg` holds:
  - State enum (IDLE/XFER/DONE).
  - `CMD_READ`=8'h03 and `CMD_FAST_READ`=8'h0B.
  - Frame-length and data-start-bit constants per configuration.
- Sub-module `spi_shifter` contains:
  - A parallel-load MSB-first output shift register driving DI.
  - An input shift register capturing DO.
  - Load, shift and sample enables.
- The top level holds the FSM, bit counter, SCK phase toggle, address latch and ready compare.

## Test plan
- Flash model preloaded with 0xA5 at address 0x000010. Request addr 0x000010 → frame on DI is 0x03,0x00,0x00,0x10; ready at cycle 81; dataOut=0xA5.
- Hold the request after ready → ready stays 1, CSbar stays 1, no new transaction. Change the address to 0x000011 (0x3C) → ready drops the same cycle; new fetch returns 0x3C after 1 idle cycle plus 81 cycles.
- Drop readMem at cycle 30 of a fetch → the transfer completes and ready never rises. Reassert readMem → a fresh fetch completes correctly.
- Assert rst at cycle 40 of a fetch → next cycle CSbar=1, SCK=0, ready=0, dataOut=0x00. A following fetch at 0xFFFFFF returns the model's byte.
- Read addresses 0..7 sequentially → all 8 bytes match the model. CSbar is high for at least 1 cycle between frames, and SCK never toggles while CSbar=1.
- With `SPI_FLASH_FAST_READ_EN` defined → the command byte is 0x0B, 8 dummy clocks occur, ready comes at cycle 97, and the data matches.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and frame constants for the SPI flash reader.
// Defining SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B) with 8 dummy bits.
package spi_flash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int unsigned FRAME_BITS = 48;
    localparam int unsigned DATA_START = 40;
    localparam logic [7:0]  CMD_BYTE   = CMD_FAST_READ;
`else
    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned DATA_START = 32;
    localparam logic [7:0]  CMD_BYTE   = CMD_READ;
`endif

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] DATA_LO   = CNT_W'(DATA_START);

    // Command and address first; dummy and data slots shift out as zeros.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [23:0] addr);
        return {CMD_BYTE, addr, {(FRAME_BITS - 32){1'b0}}};
    endfunction

endpackage

// File: rtl/spi_flash_reader_shifter.sv
// Serial datapath: MSB-first transmit shifter driving DI and receive shifter capturing DO.
module spi_shifter
    import spi_flash_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  shift,
    input  logic                  sample,
    input  logic                  sdi,
    output logic                  sdo,
    output logic [7:0]            rx_byte
);

    logic [FRAME_BITS-1:0] tx_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= '0;
            rx_byte <= '0;
        end else begin
            if (load) begin
                tx_q <= frame;
            end else if (shift) begin
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (sample) begin
                rx_byte <= {rx_byte[6:0], sdi};
            end
        end
    end

    assign sdo = tx_q[FRAME_BITS-1];

endmodule

// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash controller: byte fetch via READ, SPI mode 0, SCK = clk/2.
// Optional build macro: SPI_FLASH_FAST_READ_EN (FAST_READ with 8 dummy bits).
module spi_flash_reader
    import spi_flash_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        chipSel,
    input  logic        readMem,
    input  logic [23:0] addressBus,
    input  logic [7:0]  dataIn,
    output logic [7:0]  dataOut,
    output logic        ready,
    output logic        SCK,
    output logic        CSbar,
    output logic        DI,
    input  logic        DO
);

    state_t           state, next_state;
    logic             sck_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [23:0]      addr_q;
    logic             intact;
    logic             req, addr_match;
    logic             load, shift, sample;
    logic [7:0]       rx_byte;
    logic             unused_write;

    assign unused_write = ^dataIn;
    assign req          = chipSel && readMem;
    assign addr_match   = (addressBus == addr_q);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        sample     = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = XFER;
                    load       = 1'b1;
                end
            end
            XFER: begin
                // One extra low-SCK cycle after the last falling phase before DONE.
                if (!sck_q && bit_cnt == FRAME_LEN) begin
                    next_state = DONE;
                end else if (!sck_q) begin
                    sample = (bit_cnt >= DATA_LO);
                end else begin
                    shift = 1'b1;
                end
            end
            DONE: begin
                ready = req && addr_match && intact;
                if (!ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sck_q   <= 1'b0;
            bit_cnt <= '0;
            addr_q  <= '0;
            intact  <= 1'b0;
            dataOut <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addressBus;
                        bit_cnt <= '0;
                        sck_q   <= 1'b0;
                        intact  <= 1'b1;
                    end
                end
                XFER: begin
                    if (next_state == DONE) begin
                        dataOut <= rx_byte;
                    end else begin
                        sck_q <= ~sck_q;
                        if (sck_q) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    // A dropped or moved request still finishes but never signals ready.
                    if (!(req && addr_match)) begin
                        intact <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SCK   = sck_q;
    assign CSbar = (state != XFER);

    spi_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .frame   (build_frame(addressBus)),
        .shift   (shift),
        .sample  (sample),
        .sdi     (DO),
        .sdo     (DI),
        .rx_byte (rx_byte)
    );

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI flash model.
`timescale 1ns/1ps
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int FRAME = 48;
    localparam int DSTART = 40;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int FRAME = 40;
    localparam int DSTART = 32;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif
    localparam int LAT = 2 * FRAME + 1;
    localparam int BUDGET = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chipSel = 1'b0;
    logic        readMem = 1'b0;
    logic [23:0] addressBus = '0;
    logic [7:0]  dataIn = '0;
    logic [7:0]  dataOut;
    logic        ready, SCK, CSbar, DI;
    logic        DO = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_flash_reader dut (
        .clk        (clk),
        .rst        (rst),
        .chipSel    (chipSel),
        .readMem    (readMem),
        .addressBus (addressBus),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .ready      (ready),
        .SCK        (SCK),
        .CSbar      (CSbar),
        .DI         (DI),
        .DO         (DO)
    );

    // Flash contents: two preloaded bytes, everything else a fold of the address.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        if (a == 24'h000010) return 8'hA5;
        if (a == 24'h000011) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h69;
    endfunction

    int          rcnt = 0;
    int          last_rcnt = 0;
    int          frames = 0;
    logic [31:0] hdr = '0;
    logic [31:0] last_hdr = '0;
    logic [7:0]  mbyte = '0;

    always @(negedge CSbar) begin
        rcnt = 0;
        hdr  = '0;
    end

    always @(posedge CSbar) begin
        last_rcnt = rcnt;
        last_hdr  = hdr;
        if (rcnt == FRAME) frames++;
    end

    always @(posedge SCK) begin
        if (!CSbar) begin
            if (rcnt < 32) hdr = {hdr[30:0], DI};
            rcnt++;
            if (rcnt == 32) mbyte = fbyte(hdr[23:0]);
        end
    end

    always @(negedge SCK) begin
        if (!CSbar && rcnt >= DSTART && rcnt < FRAME) DO = mbyte[7 - (rcnt - DSTART)];
    end

    // Bus monitors: SCK must stay quiet while deselected; track shortest CSbar-high gap.
    int sck_bad = 0;
    int cs_run = 0;
    int min_gap = 1000;
    logic prev_cs = 1'b1;

    always @(posedge SCK) if (CSbar) sck_bad++;

    always @(negedge clk) begin
        if (CSbar) begin
            cs_run++;
        end else begin
            if (prev_cs && cs_run < min_gap) min_gap = cs_run;
            cs_run = 0;
        end
        prev_cs = CSbar;
    end

    task automatic start_req(input logic [23:0] a);
        @(negedge clk);
        chipSel    = 1'b1;
        readMem    = 1'b1;
        addressBus = a;
    endtask

    task automatic drop_req();
        @(negedge clk);
        chipSel = 1'b0;
        readMem = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Counts edges from the next rising edge (edge 0) until ready is seen; -1 on timeout.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int c = 0; c < BUDGET; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (CSbar !== 1'b1) begin n_bad++; $display("FAIL reset_csbar got=%b want=1", CSbar); end
        n_cmp++; if (SCK !== 1'b0) begin n_bad++; $display("FAIL reset_sck got=%b want=0", SCK); end
        n_cmp++; if (DI !== 1'b0) begin n_bad++; $display("FAIL reset_di got=%b want=0", DI); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        n_cmp++; if (dataOut !== 8'h00) begin n_bad++; $display("FAIL reset_dataout got=%h want=00", dataOut); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_read();
        int lat;
        start_req(24'h000010);
        wait_ready(lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
        n_cmp++; if (dataOut !== 8'hA5) begin n_bad++; $display("FAIL basic_data got=%h want=a5", dataOut); end
        n_cmp++; if (last_hdr !== {EXP_CMD, 24'h000010}) begin n_bad++; $display("FAIL basic_frame got=%h want=%h", last_hdr, {EXP_CMD, 24'h000010}); end
        n_cmp++; if (last_rcnt != FRAME) begin n_bad++; $display("FAIL basic_sck_count got=%0d want=%0d", last_rcnt, FRAME); end
        n_cmp++; if (CSbar !== 1'b1) begin n_bad++; $display("FAIL basic_csbar_done got=%b want=1", CSbar); end
    endtask

    task automatic test_hold_and_readdress();
        int lat, bad, f0;
        bad = 0;
        f0  = frames;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (ready !== 1'b1 || CSbar !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_ready_cycles got=%0d bad want=0", bad); end
        n_cmp++; if (frames != f0) begin n_bad++; $display("FAIL hold_no_new_frame got=%0d want=%0d", frames, f0); end
        addressBus = 24'h000011;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL readdr_ready_drop got=%b want=0", ready); end
        wait_ready(lat);
        n_cmp++; if (lat != LAT + 1) begin n_bad++; $display("FAIL readdr_latency got=%0d want=%0d", lat, LAT + 1); end
        n_cmp++; if (dataOut !== 8'h3C) begin n_bad++; $display("FAIL readdr_data got=%h want=3c", dataOut); end
    endtask

    task automatic test_drop_mid_transfer();
        int lat, f0, seen;
        drop_req();
        f0   = frames;
        seen = 0;
        start_req(24'h000020);
        for (int c = 0; c < LAT + 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 30) readMem = 1'b0;
            if (ready === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL drop_ready_seen got=%0d want=0", seen); end
        n_cmp++; if (frames != f0 + 1) begin n_bad++; $display("FAIL drop_frame_completed got=%0d want=%0d", frames, f0 + 1); end
        n_cmp++; if (dataOut !== 8'h49) begin n_bad++; $display("FAIL drop_data_updated got=%h want=49", dataOut); end
        readMem = 1'b1;
        wait_ready(lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL rearm_latency got=%0d want=%0d", lat, LAT); end
        n_cmp++; if (dataOut !== 8'h49) begin n_bad++; $display("FAIL rearm_data got=%h want=49", dataOut); end
        n_cmp++; if (frames != f0 + 2) begin n_bad++; $display("FAIL rearm_frame got=%0d want=%0d", frames, f0 + 2); end
    endtask

    task automatic test_reset_mid_transfer();
        int lat;
        drop_req();
        start_req(24'h000030);
        repeat (41) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst     = 1'b1;
        chipSel = 1'b0;
        readMem = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (CSbar !== 1'b1) begin n_bad++; $display("FAIL midrst_csbar got=%b want=1", CSbar); end
        n_cmp++; if (SCK !== 1'b0) begin n_bad++; $display("FAIL midrst_sck got=%b want=0", SCK); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got=%b want=0", ready); end
        n_cmp++; if (dataOut !== 8'h00) begin n_bad++; $display("FAIL midrst_dataout got=%h want=00", dataOut); end
        rst = 1'b0;
        start_req(24'hFFFFFF);
        wait_ready(lat);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL postrst_latency got=%0d want=%0d", lat, LAT); end
        n_cmp++; if (dataOut !== 8'h96) begin n_bad++; $display("FAIL postrst_data got=%h want=96", dataOut); end
    endtask

    task automatic test_back_to_back();
        int lat, f0;
        logic [7:0] exp_data [8] = '{8'h69, 8'h68, 8'h6B, 8'h6A, 8'h6D, 8'h6C, 8'h6F, 8'h6E};
        drop_req();
        f0      = frames;
        min_gap = 1000;
        sck_bad = 0;
        for (int a = 0; a < 8; a++) begin
            if (a == 0) begin
                start_req(24'(a));
            end else begin
                addressBus = 24'(a);
            end
            wait_ready(lat);
            n_cmp++; if (dataOut !== exp_data[a]) begin n_bad++; $display("FAIL seq_data[%0d] got=%h want=%h", a, dataOut, exp_data[a]); end
            n_cmp++; if (lat != ((a == 0) ? LAT : LAT + 1)) begin n_bad++; $display("FAIL seq_latency[%0d] got=%0d want=%0d", a, lat, (a == 0) ? LAT : LAT + 1); end
        end
        n_cmp++; if (frames != f0 + 8) begin n_bad++; $display("FAIL seq_frames got=%0d want=%0d", frames, f0 + 8); end
        n_cmp++; if (min_gap < 1) begin n_bad++; $display("FAIL seq_cs_gap got=%0d want>=1", min_gap); end
        n_cmp++; if (sck_bad != 0) begin n_bad++; $display("FAIL seq_sck_while_deselected got=%0d want=0", sck_bad); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_hold_and_readdress();
        test_drop_mid_transfer();
        test_reset_mid_transfer();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
